ode_input_loader: RTL and testbench
===================================

# ode_input_loader

Streams the ODE problem description (sizes, step, precision, time points, matrices A and B, initial X and U0) from a 64-bit valid/ready input into the four-port solver RAM. Sits directly upstream of the `ram` block and drives its write side on all four ports. Runs once per problem on a `start` pulse, before the solver core is released.

## Interface
- `DATA_WIDTH`, 64: word width on the stream and the RAM ports.
- `MAX_N`, 50: maximum value of N and M.
- `MAX_T`, 16: maximum number of time points K.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load. Ignored unless the state is IDLE or ERR.
- `in_data` in 64: stream word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the loader accepts the word this cycle.
- `address_1` out 10, `data_write_1` out 64, `WR_signal_1` out 1: RAM port 1, which holds U0, N, M and T.
- `address_2` out 12, `data_write_2` out 64, `WR_signal_2` out 1: RAM port 2, which holds A.
- `address_3` out 12, `data_write_3` out 64, `WR_signal_3` out 1: RAM port 3, which holds B.
- `address_4` out 7, `data_write_4` out 64, `WR_signal_4` out 1: RAM port 4, which holds X, H, N, E and T.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the load completes.
- `error` out 1: sticky flag for a bad header; cleared by the next accepted `start`.

## Operation
- **Stream order:**
  - N, M, H, E, K
  - T[0..K-1]
  - A (N·N words, row-major)
  - B (N·M words, row-major)
  - X (N words)
  - U0 (M words)
- **States:** IDLE → HDR_N → HDR_M → HDR_H → HDR_E → HDR_K → LD_T → LD_A → LD_B → LD_X → LD_U0 → FIN → IDLE. Any state can also go to ERR.
- A state advances only on a handshake (`in_valid & in_ready`). `in_ready` is 1 in every HDR_* and LD_* state and 0 in IDLE, FIN and ERR.
- **RAM map and per-word writes:**
  - N → port 1 address 900 and port 4 address 51.
  - M → port 1 address 901.
  - H → port 4 address 50.
  - E → port 4 address 52.
  - T[k] → port 1 address 902+k and port 4 address 53+k.
  - A[i] → port 2 address i.
  - B[i] → port 3 address i.
  - X[i] → port 4 address i.
  - U0[i] → port 1 address i.
  - K is not stored.
- **Header validation:**
  - N and M must satisfy bits [63:6] = 0 and a value of 1..50.
  - K must satisfy bits [63:5] = 0 and a value of 1..16.
  - An invalid word is consumed without being written. The FSM goes to ERR and sets `error`. RAM writes already made are not undone.
- **Counters:**
  - One 12-bit index counter, cleared on every state change.
  - `lenA` = N·N and `lenB` = N·M are registered as 12-bit products during HDR_M. The maximum, 2500, fits in 12 bits.
  - A load state ends when the word at index len−1 is accepted.
- **start handling:**
  - `start` in ERR clears `error` and enters HDR_N.
  - `start` in any other non-IDLE state is ignored.

## Timing
- **Write latency:**
  - A word accepted at edge t drives registered address, data and `WR_signal_x` = 1 during cycle t..t+1.
  - The RAM commits the word at edge t+1.
  - Each `WR_signal_x` is high for exactly one cycle per accepted word destined for that port, and 0 otherwise.
- Back-to-back words, one per cycle, are sustained; there is no bubble at state boundaries.
- **Completion:**
  - Acceptance of the last U0 word moves the FSM to FIN.
  - The last write strobe is high during the FIN cycle.
  - `done` is high for the single cycle after FIN, with `busy` = 0 in that same cycle.
- `busy` goes to 1 the cycle after an accepted `start`.
- **Reset values:** all address, data and WR outputs are 0, and `in_ready`, `busy`, `done` and `error` are 0. The state resets to IDLE.
- Address and data outputs hold their last value while WR is 0.
- **Reset mid-load:** strobes drop immediately and the partial load is abandoned. RAM contents are not cleared.
- A handshake and a `start` in the same cycle cannot occur, because `in_ready` is 0 wherever `start` is honoured.

## Structure
- Shared package `ode_pkg` holds:
  - the state enum;
  - RAM base constants (U0_BASE 0, N1_ADDR 900, M_ADDR 901, T1_BASE 902, H_ADDR 50, N4_ADDR 51, E_ADDR 52, T4_BASE 53);
  - the MAX_N and MAX_T limits.
- No sub-module. The FSM, index counter and output registers live in one module.

## Test plan
- **Nominal load:** N=2, M=1, H, E, K=2, T, 4 A words, 2 B words, 2 X words, 1 U0 word, with `in_valid` held at 1. Required response:
  - port 2 writes addresses 0..3;
  - port 3 writes addresses 0..1;
  - port 4 writes addresses 51, 50, 52, 53, 54, 0, 1;
  - port 1 writes addresses 900, 901, 902, 903, 0;
  - `done` pulses exactly once, 2 cycles after the last handshake.
- **Maximum sizes:** N=50, M=50, K=16. Port 2 last address is 2499; port 1 last T address is 917; port 4 last T address is 68.
- **Bad header:** N=51. `error` goes to 1, `in_ready` goes to 0 and no write occurs for that word; a following `start` clears `error` and restarts at HDR_N.
- **Stalls:** `in_valid` randomly deasserted. The write sequence is identical to the nominal case; no strobe occurs on a cycle without a preceding handshake.
- **Reset mid-load:** `rst_n` asserted low during LD_A. All WR strobes are 0 immediately and the FSM is in IDLE after release; a new `start` completes a full load.
- **start while busy:** a `start` pulse during LD_B has no effect on the sequence, and `done` pulses once.

Source files
------------

// File: rtl/ode_input_loader_pkg.sv
// Shared types and RAM map constants for the ODE problem loader.
// Imported by the loader top; limits also seed its parameters.
package ode_pkg;

    localparam int MAX_N = 50;
    localparam int MAX_T = 16;

    localparam int U0_BASE = 0;
    localparam int N1_ADDR = 900;
    localparam int M_ADDR  = 901;
    localparam int T1_BASE = 902;
    localparam int H_ADDR  = 50;
    localparam int N4_ADDR = 51;
    localparam int E_ADDR  = 52;
    localparam int T4_BASE = 53;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_N,
        S_HDR_M,
        S_HDR_H,
        S_HDR_E,
        S_HDR_K,
        S_LD_T,
        S_LD_A,
        S_LD_B,
        S_LD_X,
        S_LD_U0,
        S_FIN,
        S_ERR
    } state_e;

endpackage

// File: rtl/ode_input_loader_if.sv
// Input stream and four RAM write ports of the ODE loader.
// master = loader side, slave = stream source / RAM side.
interface ode_input_loader_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    logic [9:0]            address_1;
    logic [DATA_WIDTH-1:0] data_write_1;
    logic                  WR_signal_1;
    logic [11:0]           address_2;
    logic [DATA_WIDTH-1:0] data_write_2;
    logic                  WR_signal_2;
    logic [11:0]           address_3;
    logic [DATA_WIDTH-1:0] data_write_3;
    logic                  WR_signal_3;
    logic [6:0]            address_4;
    logic [DATA_WIDTH-1:0] data_write_4;
    logic                  WR_signal_4;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output address_1, data_write_1, WR_signal_1,
        output address_2, data_write_2, WR_signal_2,
        output address_3, data_write_3, WR_signal_3,
        output address_4, data_write_4, WR_signal_4
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  address_1, data_write_1, WR_signal_1,
        input  address_2, data_write_2, WR_signal_2,
        input  address_3, data_write_3, WR_signal_3,
        input  address_4, data_write_4, WR_signal_4
    );

endinterface

// File: rtl/ode_input_loader.sv
// Streams an ODE problem (header, T, A, B, X, U0) into the
// four-port solver RAM, one registered write per accepted word.
module ode_input_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_N      = ode_pkg::MAX_N,
    parameter int MAX_T      = ode_pkg::MAX_T
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    ode_input_loader_if.master bus,
    output logic busy,
    output logic done,
    output logic error
);
    import ode_pkg::*;

    state_e      state_q, state_d;
    logic [11:0] idx_q, len_a_q, len_b_q;
    logic [5:0]  n_q, m_q;
    logic [4:0]  k_q;
    logic        ready, hs, nm_ok, k_ok, last;
    logic        we1, we2, we3, we4;
    logic [9:0]  a1_d;
    logic [11:0] a2_d, a3_d;
    logic [6:0]  a4_d;

    assign ready = !(state_q inside {S_IDLE, S_FIN, S_ERR});
    assign hs    = bus.in_valid & ready;
    assign bus.in_ready = ready;

    assign nm_ok = (bus.in_data[DATA_WIDTH-1:6] == '0)
                && (bus.in_data[5:0] != 6'd0)
                && (int'(bus.in_data[5:0]) <= MAX_N);
    assign k_ok  = (bus.in_data[DATA_WIDTH-1:5] == '0)
                && (bus.in_data[4:0] != 5'd0)
                && (int'(bus.in_data[4:0]) <= MAX_T);

    always_comb begin
        state_d = state_q;
        we1  = 1'b0;
        we2  = 1'b0;
        we3  = 1'b0;
        we4  = 1'b0;
        a1_d = '0;
        a2_d = '0;
        a3_d = '0;
        a4_d = '0;
        last = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERR: if (start) state_d = S_HDR_N;
            S_HDR_N: if (hs) begin
                if (nm_ok) begin
                    we1 = 1'b1;
                    we4 = 1'b1;
                    a1_d = 10'(N1_ADDR);
                    a4_d = 7'(N4_ADDR);
                    state_d = S_HDR_M;
                end else state_d = S_ERR;
            end
            S_HDR_M: if (hs) begin
                if (nm_ok) begin
                    we1 = 1'b1;
                    a1_d = 10'(M_ADDR);
                    state_d = S_HDR_H;
                end else state_d = S_ERR;
            end
            S_HDR_H: if (hs) begin
                we4 = 1'b1;
                a4_d = 7'(H_ADDR);
                state_d = S_HDR_E;
            end
            S_HDR_E: if (hs) begin
                we4 = 1'b1;
                a4_d = 7'(E_ADDR);
                state_d = S_HDR_K;
            end
            // K only sizes the T block; it has no RAM slot
            S_HDR_K: if (hs) state_d = k_ok ? S_LD_T : S_ERR;
            S_LD_T: begin
                last = idx_q == {7'd0, k_q} - 12'd1;
                if (hs) begin
                    we1 = 1'b1;
                    we4 = 1'b1;
                    a1_d = 10'(T1_BASE) + idx_q[9:0];
                    a4_d = 7'(T4_BASE) + idx_q[6:0];
                    if (last) state_d = S_LD_A;
                end
            end
            S_LD_A: begin
                last = idx_q == len_a_q - 12'd1;
                if (hs) begin
                    we2 = 1'b1;
                    a2_d = idx_q;
                    if (last) state_d = S_LD_B;
                end
            end
            S_LD_B: begin
                last = idx_q == len_b_q - 12'd1;
                if (hs) begin
                    we3 = 1'b1;
                    a3_d = idx_q;
                    if (last) state_d = S_LD_X;
                end
            end
            S_LD_X: begin
                last = idx_q == {6'd0, n_q} - 12'd1;
                if (hs) begin
                    we4 = 1'b1;
                    a4_d = idx_q[6:0];
                    if (last) state_d = S_LD_U0;
                end
            end
            S_LD_U0: begin
                last = idx_q == {6'd0, m_q} - 12'd1;
                if (hs) begin
                    we1 = 1'b1;
                    a1_d = 10'(U0_BASE) + idx_q[9:0];
                    if (last) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            len_a_q <= '0;
            len_b_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) idx_q <= '0;
            else if (hs)            idx_q <= idx_q + 12'd1;
            if (state_q == S_HDR_N && hs && nm_ok)
                n_q <= bus.in_data[5:0];
            if (state_q == S_HDR_M && hs && nm_ok) begin
                m_q     <= bus.in_data[5:0];
                len_a_q <= 12'(n_q) * 12'(n_q);
                len_b_q <= 12'(n_q) * 12'(bus.in_data[5:0]);
            end
            if (state_q == S_HDR_K && hs && k_ok)
                k_q <= bus.in_data[4:0];
            if (state_q inside {S_IDLE, S_ERR} && start)
                busy <= 1'b1;
            else if (state_q == S_FIN || state_d == S_ERR)
                busy <= 1'b0;
            done  <= state_q == S_FIN;
            // ERR is left only through start, so this stays sticky
            error <= state_d == S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.WR_signal_1  <= 1'b0;
            bus.WR_signal_2  <= 1'b0;
            bus.WR_signal_3  <= 1'b0;
            bus.WR_signal_4  <= 1'b0;
            bus.address_1    <= '0;
            bus.address_2    <= '0;
            bus.address_3    <= '0;
            bus.address_4    <= '0;
            bus.data_write_1 <= '0;
            bus.data_write_2 <= '0;
            bus.data_write_3 <= '0;
            bus.data_write_4 <= '0;
        end else begin
            bus.WR_signal_1 <= we1;
            bus.WR_signal_2 <= we2;
            bus.WR_signal_3 <= we3;
            bus.WR_signal_4 <= we4;
            if (we1) begin
                bus.address_1    <= a1_d;
                bus.data_write_1 <= bus.in_data;
            end
            if (we2) begin
                bus.address_2    <= a2_d;
                bus.data_write_2 <= bus.in_data;
            end
            if (we3) begin
                bus.address_3    <= a3_d;
                bus.data_write_3 <= bus.in_data;
            end
            if (we4) begin
                bus.address_4    <= a4_d;
                bus.data_write_4 <= bus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_ode_input_loader.sv
// Scoreboard bench for ode_input_loader: random problems and stalls,
// expected RAM writes derived from the stream order and RAM map.
module tb_ode_input_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;

    ode_input_loader_if #(.DATA_WIDTH(64)) bus();

    ode_input_loader #(
        .DATA_WIDTH(64),
        .MAX_N(50),
        .MAX_T(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        int          addr;
        logic [63:0] data;
    } wr_t;

    logic [63:0] words[$];
    wr_t wa[$];
    wr_t wb[$];
    wr_t q1[$];
    wr_t q2[$];
    wr_t q3[$];
    wr_t q4[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int last_a2 = -1;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string nm,
                                input longint got,
                                input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic void push(input wr_t w);
        case (w.port)
            1: q1.push_back(w);
            2: q2.push_back(w);
            3: q3.push_back(w);
            4: q4.push_back(w);
            default: ;
        endcase
    endfunction

    function automatic void clear_q();
        q1.delete();
        q2.delete();
        q3.delete();
        q4.delete();
    endfunction

    function automatic void add(input logic [63:0] w,
                                input int pa, input int aa,
                                input int pb, input int ab);
        words.push_back(w);
        wa.push_back('{pa, aa, w});
        wb.push_back('{pb, ab, w});
    endfunction

    function automatic void new_stream();
        words.delete();
        wa.delete();
        wb.delete();
    endfunction

    // Reference: stream order and RAM map of a complete problem
    function automatic void build_load(input int n, input int m,
                                       input int k);
        new_stream();
        add(64'(n), 1, 900, 4, 51);
        add(64'(m), 1, 901, 0, 0);
        add(rnd64(), 4, 50, 0, 0);
        add(rnd64(), 4, 52, 0, 0);
        add(64'(k), 0, 0, 0, 0);
        for (int t = 0; t < k; t++) add(rnd64(), 1, 902 + t, 4, 53 + t);
        for (int i = 0; i < n * n; i++) add(rnd64(), 2, i, 0, 0);
        for (int i = 0; i < n * m; i++) add(rnd64(), 3, i, 0, 0);
        for (int i = 0; i < n; i++) add(rnd64(), 4, i, 0, 0);
        for (int i = 0; i < m; i++) add(rnd64(), 1, i, 0, 0);
    endfunction

    function automatic void mon_port(input int p, input logic wr,
                                     input int a,
                                     input logic [63:0] d);
        wr_t e;
        int sz;
        if (!wr) return;
        case (p)
            1: sz = q1.size();
            2: sz = q2.size();
            3: sz = q3.size();
            default: sz = q4.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL p%0d_unexpected: got write addr %0d expected none",
                     p, a);
            return;
        end
        case (p)
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            3: e = q3.pop_front();
            default: e = q4.pop_front();
        endcase
        chk($sformatf("p%0d_addr", p), longint'(a), longint'(e.addr));
        chk($sformatf("p%0d_data", p), longint'(d), longint'(e.data));
        if (p == 2) last_a2 = a;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(1, bus.WR_signal_1, int'(bus.address_1),
                     bus.data_write_1);
            mon_port(2, bus.WR_signal_2, int'(bus.address_2),
                     bus.data_write_2);
            mon_port(3, bus.WR_signal_3, int'(bus.address_3),
                     bus.data_write_3);
            mon_port(4, bus.WR_signal_4, int'(bus.address_4),
                     bus.data_write_4);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", longint'(busy), 0);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        chk("error_after_start", longint'(error), 0);
    endtask

    // Returns just after the edge that accepted the last word
    task automatic send(input int nw, input int stall_pct,
                        input int start_at);
        int  i = 0;
        int  budget = 0;
        bit  hs;
        while (i < nw) begin
            @(negedge clk);
            if (budget++ > 20000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got %0d words expected %0d",
                         i, nw);
                break;
            end
            bus.in_valid = ($urandom_range(99) >= stall_pct);
            bus.in_data  = bus.in_valid ? words[i] : rnd64();
            start = (start_at >= 0 && i == start_at);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                push(wa[i]);
                push(wb[i]);
                last_hs_cyc = cyc;
                i++;
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input int m, input int k,
                            input int stall, input int start_at);
        build_load(n, m, k);
        done_cnt = 0;
        do_start();
        send(words.size(), stall, start_at);
        for (int c = 0; c < 10 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("done_count", longint'(done_cnt), 1);
        // accept edge -> FIN -> done visible after the following edge
        chk("done_edges_after_last_hs",
            longint'(done_cyc - last_hs_cyc), 1);
        chk("writes_pending",
            longint'(q1.size() + q2.size() + q3.size() + q4.size()), 0);
        chk("busy_idle", longint'(busy), 0);
        chk("error_ok", longint'(error), 0);
    endtask

    task automatic bad_header(input int kind);
        new_stream();
        case (kind)
            0: add(64'd51, 0, 0, 0, 0);
            1: add(64'd0, 0, 0, 0, 0);
            2: begin
                add(64'd3, 1, 900, 4, 51);
                add({1'b1, 63'd4}, 0, 0, 0, 0);
            end
            default: begin
                add(64'd2, 1, 900, 4, 51);
                add(64'd2, 1, 901, 0, 0);
                add(rnd64(), 4, 50, 0, 0);
                add(rnd64(), 4, 52, 0, 0);
                add(kind == 3 ? 64'd17 : 64'd0, 0, 0, 0, 0);
            end
        endcase
        do_start();
        send(words.size(), 0, -1);
        repeat (3) @(negedge clk);
        chk($sformatf("bad%0d_error", kind), longint'(error), 1);
        chk($sformatf("bad%0d_in_ready", kind), longint'(bus.in_ready), 0);
        chk($sformatf("bad%0d_pending", kind),
            longint'(q1.size() + q2.size() + q3.size() + q4.size()), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_error", longint'(error), 0);
        chk("rst_wr",
            longint'({bus.WR_signal_1, bus.WR_signal_2,
                      bus.WR_signal_3, bus.WR_signal_4}), 0);
        chk("rst_addr1", longint'(bus.address_1), 0);
        chk("rst_addr4", longint'(bus.address_4), 0);
        chk("rst_data2", longint'(bus.data_write_2), 0);
        rst_n = 1'b1;

        run_load(2, 1, 2, 0, -1);
        run_load(2, 1, 2, 50, -1);
        repeat (5) run_load($urandom_range(1, 6), $urandom_range(1, 6),
                            $urandom_range(1, 5), 40, -1);

        run_load(50, 50, 16, 0, -1);
        chk("max_last_a2", longint'(last_a2), 2499);

        for (int b = 0; b < 5; b++) begin
            bad_header(b);
            run_load($urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), 20, -1);
        end

        // Abandon a load inside A while a write strobe is active
        build_load(3, 2, 2);
        do_start();
        send(5 + 2 + 4, 0, -1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr",
            longint'({bus.WR_signal_1, bus.WR_signal_2,
                      bus.WR_signal_3, bus.WR_signal_4}), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 0);
        clear_q();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_ready", longint'(bus.in_ready), 0);
        chk("midrst_busy", longint'(busy), 0);
        run_load(3, 2, 2, 30, -1);

        run_load(3, 2, 2, 0, 5 + 2 + 9 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
